// File: rtl/calc_pkg.sv
// calc_pkg: shared types and default timing for the stack calculator front end.
// Timing constants are also used by the board top and the benches.
package calc_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } kc_state_t;

  // Default timing at the board clock rate.
  localparam int KC_DEBOUNCE_CYCLES = 500000;
  localparam int KC_REPEAT_DELAY    = 25000000;
  localparam int KC_REPEAT_PERIOD   = 5000000;

endpackage : calc_pkg

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs, with a
// configurable reset value so idle levels are correct straight out of reset.
module sync_2ff #(
  parameter int                 WIDTH   = 1,
  parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] q_out
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  // Next-state: shift the raw input through the two stages.
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  // Synchroniser flops, synchronous reset to the idle level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_out = sync_q;

endmodule : sync_2ff

// File: rtl/key_conditioner.sv
// key_conditioner: synchronises and debounces the execute key, freezes the
// mode switches for the duration of a press and drives the control unit.
// Optional feature macro: AUTOREPEAT_EN (auto-repeat while the key is held).
//
// state        | meaning
// IDLE         | key released; mode tracks the switches
// PRESS_WAIT   | key seen low, waiting for it to stay low long enough
// PRESSED      | press accepted, ex_n low
// RELEASE_WAIT | key seen high, waiting for it to stay high long enough
module key_conditioner
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KC_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = KC_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = KC_REPEAT_PERIOD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw_n,
  input  logic [1:0] sw_mode,
  output logic       ex_n,
  output logic [1:0] mode,
  output logic       ex_pulse,
  output logic       busy
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Catch nonsensical timing at elaboration rather than in the field.
  generate
    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2 || REPEAT_DELAY < 1) begin : g_bad_timing
      $error("key_conditioner: timing parameters out of range");
    end
  endgenerate

  logic       key_s;
  logic [1:0] mode_s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync_key (
    .clk   (clk),
    .rst   (rst),
    .d_in  (key_raw_n),
    .q_out (key_s)
  );

  sync_2ff #(
    .WIDTH   (2),
    .RST_VAL (2'b00)
  ) u_sync_mode (
    .clk   (clk),
    .rst   (rst),
    .d_in  (sw_mode),
    .q_out (mode_s)
  );

  kc_state_t        state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             ex_n_d, ex_n_q;
  logic [1:0]       mode_d, mode_q;
  logic             ex_pulse_d, ex_pulse_q;
  logic             busy_d, busy_q;

`ifdef AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = $clog2(RPT_MAX);
  localparam logic [RCNT_W-1:0] RPT_FIRST_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RPT_NEXT_LAST  = RCNT_W'(REPEAT_PERIOD - 1);

  logic [RCNT_W-1:0] rcnt_d, rcnt_q;
  logic              rpt_first_d, rpt_first_q;
`endif

  // Next-state logic for the debounce FSM, its counter and the registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ex_n_d     = ex_n_q;
    mode_d     = mode_q;
    ex_pulse_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!key_s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end else begin
          mode_d = mode_s;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = PRESSED;
          cnt_d      = '0;
          ex_n_d     = 1'b0;
          ex_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          ex_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        ex_n_d  = 1'b1;
      end
    endcase

`ifdef AUTOREPEAT_EN
    // Repeat schedule: it restarts only when a new press begins, and merely
    // pauses during RELEASE_WAIT so a release bounce does not push it back.
    rcnt_d      = rcnt_q;
    rpt_first_d = rpt_first_q;

    // The one-cycle high of a repeat always ends with a fresh falling edge.
    if (state_q == PRESSED && ex_n_q) begin
      ex_n_d     = 1'b0;
      ex_pulse_d = 1'b1;
    end

    case (state_q)
      IDLE, PRESS_WAIT: begin
        rcnt_d      = '0;
        rpt_first_d = 1'b1;
      end
      PRESSED: begin
        if (!key_s) begin
          if (rcnt_q == (rpt_first_q ? RPT_FIRST_LAST : RPT_NEXT_LAST)) begin
            ex_n_d      = 1'b1;
            rcnt_d      = '0;
            rpt_first_d = 1'b0;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
`endif

    busy_d = (state_d != IDLE);
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ex_n_q     <= 1'b1;
      mode_q     <= 2'b00;
      ex_pulse_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ex_n_q     <= ex_n_d;
      mode_q     <= mode_d;
      ex_pulse_q <= ex_pulse_d;
      busy_q     <= busy_d;
    end
  end

`ifdef AUTOREPEAT_EN
  // Repeat counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q      <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rcnt_q      <= rcnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`endif

  assign ex_n     = ex_n_q;
  assign mode     = mode_q;
  assign ex_pulse = ex_pulse_q;
  assign busy     = busy_q;

endmodule : key_conditioner
